fsb_arbiter: RTL and testbench

Front-side bus arbiter and access sequencer between two 8-bit Wishbone masters (M0 = CPU, M1 = DMA/debug) and the single external FSB. It consumes the `SYNC_MODE` / `ASYNC_WAITCYCLE` configuration exported by the system controller. It grants the bus round-robin and runs each access in one of two modes:
- sync: terminated by the slave's ACK.
- async: a fixed wait count.

It sits between the core-side interconnect and the FSB pads.

---
 rtl/fsb_arbiter_if.sv | 47 ++++
 rtl/fsb_arbiter.sv | 119 +++++++++++
 tb/tb_fsb_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsb_arbiter_if.sv
// Signal bundle linking the two Wishbone masters, the system controller config and the FSB pads.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface fsb_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              SYNC_MODE;
  logic [6:0]        ASYNC_WAITCYCLE;

  logic [ADDR_W-1:0] M0_ADRi;
  logic [ADDR_W-1:0] M1_ADRi;
  logic [7:0]        M0_DATi;
  logic [7:0]        M1_DATi;
  logic [7:0]        M0_DATo;
  logic [7:0]        M1_DATo;
  logic              M0_WEi, M0_CYCi, M0_STBi, M0_ACKo;
  logic              M1_WEi, M1_CYCi, M1_STBi, M1_ACKo;

  logic [ADDR_W-1:0] FSB_ADRo;
  logic [7:0]        FSB_DATo;
  logic [7:0]        FSB_DATi;
  logic              FSB_WEo, FSB_CYCo, FSB_STBo, FSB_ACKi;

  logic              TIMEOUT_o;
  logic              TIMEOUT_CLRi;

  modport slave (
    input  SYNC_MODE, ASYNC_WAITCYCLE,
    input  M0_ADRi, M1_ADRi, M0_DATi, M1_DATi,
    input  M0_WEi, M0_CYCi, M0_STBi, M1_WEi, M1_CYCi, M1_STBi,
    output M0_DATo, M1_DATo, M0_ACKo, M1_ACKo,
    output FSB_ADRo, FSB_DATo, FSB_WEo, FSB_CYCo, FSB_STBo,
    input  FSB_DATi, FSB_ACKi,
    output TIMEOUT_o,
    input  TIMEOUT_CLRi
  );

  modport master (
    output SYNC_MODE, ASYNC_WAITCYCLE,
    output M0_ADRi, M1_ADRi, M0_DATi, M1_DATi,
    output M0_WEi, M0_CYCi, M0_STBi, M1_WEi, M1_CYCi, M1_STBi,
    input  M0_DATo, M1_DATo, M0_ACKo, M1_ACKo,
    input  FSB_ADRo, FSB_DATo, FSB_WEo, FSB_CYCo, FSB_STBo,
    output FSB_DATi, FSB_ACKi,
    input  TIMEOUT_o,
    output TIMEOUT_CLRi
  );
endinterface

// File: rtl/fsb_arbiter.sv
// Round-robin FSB arbiter for two 8-bit Wishbone masters, sync (ACK) or async (wait count) accesses.
// Define FSB_TIMEOUT_EN to abort sync accesses after 256 unacknowledged cycles.
module fsb_arbiter #(
  parameter int ADDR_W = 24
) (
  input logic         clk,
  input logic         rst,
  fsb_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic              last_m1;
  logic              grant_m1;
  logic              mode_sync;
  logic [6:0]        wait_cnt;
  logic [7:0]        rdata;
  logic              req0, req1, win1;
  logic [ADDR_W-1:0] win_adr;
  logic              timed_out;
  logic              finish;

  assign req0    = bus.M0_CYCi & bus.M0_STBi;
  assign req1    = bus.M1_CYCi & bus.M1_STBi;
  // On a tie the master that was not granted last takes the bus.
  assign win1    = req1 & (~req0 | ~last_m1);
  assign win_adr = win1 ? bus.M1_ADRi : bus.M0_ADRi;
  assign finish  = mode_sync ? (bus.FSB_ACKi | timed_out) : (wait_cnt == 7'd0);

  assign bus.M0_DATo = rdata;
  assign bus.M1_DATo = rdata;

`ifdef FSB_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       timeout_q;

  assign timed_out     = mode_sync & ~bus.FSB_ACKi & (to_cnt == 8'hFF);
  assign bus.TIMEOUT_o = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt <= (state == ACCESS) ? to_cnt + 8'd1 : 8'd0;
      if (bus.TIMEOUT_CLRi)
        timeout_q <= 1'b0;
      else if (state == ACCESS && timed_out)
        timeout_q <= 1'b1;
    end
  end
`else
  logic unused_clr;

  assign timed_out     = 1'b0;
  assign bus.TIMEOUT_o = 1'b0;
  assign unused_clr    = bus.TIMEOUT_CLRi;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_m1      <= 1'b1;
      grant_m1     <= 1'b0;
      mode_sync    <= 1'b0;
      wait_cnt     <= 7'd0;
      rdata        <= 8'h00;
      bus.FSB_ADRo <= '0;
      bus.FSB_DATo <= 8'h00;
      bus.FSB_WEo  <= 1'b0;
      bus.FSB_CYCo <= 1'b0;
      bus.FSB_STBo <= 1'b0;
      bus.M0_ACKo  <= 1'b0;
      bus.M1_ACKo  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.M0_ACKo <= 1'b0;
          bus.M1_ACKo <= 1'b0;
          if (req0 | req1) begin
            grant_m1     <= win1;
            bus.FSB_ADRo <= win_adr;
            bus.FSB_DATo <= win1 ? bus.M1_DATi : bus.M0_DATi;
            bus.FSB_WEo  <= win1 ? bus.M1_WEi : bus.M0_WEi;
            bus.FSB_CYCo <= 1'b1;
            bus.FSB_STBo <= 1'b1;
            mode_sync    <= bus.SYNC_MODE;
            wait_cnt     <= bus.ASYNC_WAITCYCLE;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (finish) begin
            rdata        <= timed_out ? 8'hFF : bus.FSB_DATi;
            bus.FSB_WEo  <= 1'b0;
            bus.FSB_CYCo <= 1'b0;
            bus.FSB_STBo <= 1'b0;
            bus.M0_ACKo  <= ~grant_m1;
            bus.M1_ACKo  <= grant_m1;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 7'd1;
          end
        end
        DONE: begin
          bus.M0_ACKo <= 1'b0;
          bus.M1_ACKo <= 1'b0;
          last_m1     <= grant_m1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsb_arbiter.sv
// Randomized bench for fsb_arbiter against a transaction-level model of grants, strobe length and read data.
// Timeout scenarios run only when built with FSB_TIMEOUT_EN.
module tb_fsb_arbiter;

  localparam int ADDR_W = 24;
`ifdef FSB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  fsb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  fsb_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_grant = 1;
  bit tflag = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic dropRequests();
    bus.M0_CYCi = 1'b0; bus.M0_STBi = 1'b0;
    bus.M1_CYCi = 1'b0; bus.M1_STBi = 1'b0;
  endtask

  // One access from request to the idle cycle after ACK; called at a negedge with the arbiter idle.
  task automatic applyStimulus(input bit r0, input bit r1, input bit sync, input int w, input int k,
                               input bit flip, input bit hold, input int clr_at);
    int winner, waited, strobes, exp_len;
    bit stable, to_hit;
    logic [7:0] last_dat, exp_rd;
    logic [ADDR_W-1:0] exp_adr;
    logic [7:0] exp_wd;
    logic exp_we;

    bus.M0_ADRi = ADDR_W'($urandom);
    bus.M1_ADRi = ADDR_W'($urandom);
    bus.M0_DATi = 8'($urandom);
    bus.M1_DATi = 8'($urandom);
    bus.M0_WEi  = 1'($urandom);
    bus.M1_WEi  = 1'($urandom);
    bus.M0_CYCi = r0; bus.M0_STBi = r0;
    bus.M1_CYCi = r1; bus.M1_STBi = r1;
    bus.SYNC_MODE = sync;
    bus.ASYNC_WAITCYCLE = 7'(w);

    if (r0 && r1) winner = 1 - last_grant;
    else          winner = r1 ? 1 : 0;
    exp_adr = (winner == 1) ? bus.M1_ADRi : bus.M0_ADRi;
    exp_wd  = (winner == 1) ? bus.M1_DATi : bus.M0_DATi;
    exp_we  = (winner == 1) ? bus.M1_WEi  : bus.M0_WEi;
    to_hit  = TO_EN && sync && (k > 256);
    exp_len = sync ? (to_hit ? 256 : k) : w + 1;

    waited = 0;
    @(negedge clk);
    while (!bus.FSB_STBo && waited < 4) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("grant_latency", waited, 0);

    strobes = 0;
    stable = 1'b1;
    last_dat = 8'h00;
    while (bus.FSB_STBo && strobes < 400) begin
      strobes++;
      if (bus.FSB_CYCo !== 1'b1 || bus.FSB_ADRo !== exp_adr || bus.FSB_WEo !== exp_we ||
          bus.FSB_DATo !== exp_wd || bus.M0_ACKo !== 1'b0 || bus.M1_ACKo !== 1'b0)
        stable = 1'b0;
      last_dat = 8'($urandom);
      bus.FSB_DATi = last_dat;
      bus.FSB_ACKi = sync ? (strobes == k) : 1'($urandom);
      bus.TIMEOUT_CLRi = (strobes == clr_at);
      if (flip && strobes == 1) begin
        bus.SYNC_MODE = ~bus.SYNC_MODE;
        bus.ASYNC_WAITCYCLE = 7'($urandom);
      end
      @(negedge clk);
    end
    bus.FSB_ACKi = 1'b0;
    bus.TIMEOUT_CLRi = 1'b0;

    if (TO_EN) begin
      if (clr_at >= 1 && clr_at <= exp_len) tflag = 1'b0;
      if (to_hit && clr_at != exp_len)     tflag = 1'b1;
    end
    exp_rd = to_hit ? 8'hFF : last_dat;

    checkOutput("strobe_len", strobes, exp_len);
    checkOutput("bus_stable", 32'(stable), 1);
    checkOutput("m0_ack", bus.M0_ACKo, 32'(winner == 0));
    checkOutput("m1_ack", bus.M1_ACKo, 32'(winner == 1));
    checkOutput("m0_rdata", bus.M0_DATo, exp_rd);
    checkOutput("m1_rdata", bus.M1_DATo, exp_rd);
    checkOutput("strobes_low", {bus.FSB_CYCo, bus.FSB_STBo, bus.FSB_WEo}, 0);
    checkOutput("timeout_flag", bus.TIMEOUT_o, 32'(tflag));

    if (!hold) dropRequests();
    last_grant = winner;
    @(negedge clk);
    checkOutput("idle_gap", {bus.M0_ACKo, bus.M1_ACKo, bus.FSB_STBo}, 0);
  endtask

  initial begin
    dropRequests();
    bus.M0_ADRi = '0; bus.M1_ADRi = '0;
    bus.M0_DATi = 8'h00; bus.M1_DATi = 8'h00;
    bus.M0_WEi = 1'b0; bus.M1_WEi = 1'b0;
    bus.FSB_DATi = 8'h00; bus.FSB_ACKi = 1'b0;
    bus.SYNC_MODE = 1'b0; bus.ASYNC_WAITCYCLE = 7'd0;
    bus.TIMEOUT_CLRi = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_strobes", {bus.FSB_CYCo, bus.FSB_STBo, bus.FSB_WEo}, 0);
    checkOutput("rst_adr", bus.FSB_ADRo, 0);
    checkOutput("rst_dat", bus.FSB_DATo, 0);
    checkOutput("rst_acks", {bus.M0_ACKo, bus.M1_ACKo}, 0);
    checkOutput("rst_rdata", {bus.M0_DATo, bus.M1_DATo}, 0);
    checkOutput("rst_timeout", bus.TIMEOUT_o, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 5, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 127, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);

    $display("[TB] held simultaneous requests");
    applyStimulus(1, 1, 0, 2, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 3, 0, 1, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 2, 0, 0, 0);

    $display("[TB] mode change mid-access");
    applyStimulus(1, 0, 0, 6, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 4, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 3, 1, 0, 0);
    applyStimulus(0, 1, 0, 5, 0, 0, 0, 0);

    if (TO_EN) begin
      $display("[TB] timeout handling");
      applyStimulus(1, 0, 1, 0, 1000, 0, 0, 0);
      bus.TIMEOUT_CLRi = 1'b1;
      @(negedge clk);
      bus.TIMEOUT_CLRi = 1'b0;
      tflag = 1'b0;
      checkOutput("timeout_clear", bus.TIMEOUT_o, 0);
      applyStimulus(0, 1, 1, 0, 1000, 0, 0, 256);
      applyStimulus(1, 0, 0, 4, 0, 0, 0, 0);
    end else begin
      $display("[TB] long sync wait");
      applyStimulus(1, 0, 1, 0, 300, 0, 0, 0);
      bus.TIMEOUT_CLRi = 1'b1;
      @(negedge clk);
      bus.TIMEOUT_CLRi = 1'b0;
      checkOutput("timeout_tied", bus.TIMEOUT_o, 0);
    end

    $display("[TB] reset during async access");
    bus.M0_CYCi = 1'b1; bus.M0_STBi = 1'b1;
    bus.M0_ADRi = ADDR_W'(24'h00ABCD);
    bus.SYNC_MODE = 1'b0; bus.ASYNC_WAITCYCLE = 7'd10;
    @(negedge clk);
    checkOutput("pre_rst_stb", bus.FSB_STBo, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dropRequests();
    @(negedge clk);
    rst = 1'b0;
    last_grant = 1;
    tflag = 1'b0;
    checkOutput("midrst_strobes", {bus.FSB_CYCo, bus.FSB_STBo, bus.FSB_WEo}, 0);
    checkOutput("midrst_adr", bus.FSB_ADRo, 0);
    checkOutput("midrst_acks", {bus.M0_ACKo, bus.M1_ACKo}, 0);
    checkOutput("midrst_rdata", bus.M0_DATo, 0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_ack", {bus.M0_ACKo, bus.M1_ACKo, bus.FSB_STBo}, 0);
    applyStimulus(0, 1, 0, 2, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      applyStimulus(sel[0], sel[1], 1'($urandom),
                    ($urandom_range(0, 9) == 0) ? 127 : $urandom_range(0, 15),
                    $urandom_range(1, 12), ($urandom_range(0, 4) == 0), 1'($urandom), 0);
      if (bus.M0_CYCi || bus.M1_CYCi) begin
        if (!(bus.M0_CYCi && bus.M1_CYCi)) dropRequests();
      end
    end
    dropRequests();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
